idu: RTL and testbench

IDU -- requirements
Module: idu

---
 rtl/idu_pkg.sv | 82 ++++++++
 rtl/idu_if.sv | 21 ++
 rtl/idu_imm_gen.sv | 23 ++
 rtl/idu.sv | 151 +++++++++++++++
 tb/tb_idu.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idu_pkg.sv
// Shared pipeline types: fetch/decode payloads, ALU and operand-select
// encodings, immediate formats and RV32I opcode constants.
package pipeline;

    typedef struct packed {
        logic [31:2] instr;
        logic [31:0] curr_pc;
        logic [31:0] inc_pc;
    } decode_signals;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1, SRC_A_PC, SRC_A_ZERO
    } src_a_sel_e;

    typedef enum logic {
        SRC_B_RS2, SRC_B_IMM
    } src_b_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e     alu_op;
        src_a_sel_e  src_a_sel;
        src_b_sel_e  src_b_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        illegal;
        logic [31:0] curr_pc;
        logic [31:0] inc_pc;
    } execute_signals;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ADDI x0,x0,0 as seen without the implicit 2'b11; the ifu's no-ack filler
    localparam logic [31:2] INSTR_FILLER = 30'h4;

    // An all-zero payload: no enables, not illegal, pc fields cleared
    localparam execute_signals EX_BUBBLE = '0;

    // funct3 -> ALU operation; alt selects SUB (000) or SRA (101)
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_if.sv
// Decode-stage bus: fetched instruction in, register read addresses,
// stall back to the ifu, and the registered ID/EX payload out.
interface idu_if;
    pipeline::decode_signals  signals_in;
    logic                     stall_in;
    logic                     flush;
    logic [4:0]               rs1_addr;
    logic [4:0]               rs2_addr;
    logic                     stall_out;
    pipeline::execute_signals signals_out;

    modport master (
        output signals_in, stall_in, flush,
        input  rs1_addr, rs2_addr, stall_out, signals_out
    );

    modport slave (
        input  signals_in, stall_in, flush,
        output rs1_addr, rs2_addr, stall_out, signals_out
    );
endinterface

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended per format.
module imm_gen
    import pipeline::*;
(
    input  logic [31:2] instr,
    input  imm_fmt_e    format,
    output logic [31:0] imm
);

    // Select and sign-extend the immediate bits for the given format
    always_comb begin
        imm = '0;
        case (format)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/idu.sv
// Instruction decode stage: RV32I decode, load-use interlock and the
// ID/EX pipeline register.
module idu
    import pipeline::*;
#(
    parameter int unsigned LOAD_USE_INTERLOCK = 1
) (
    input  logic clk,
    input  logic reset_n,
    idu_if.slave bus
);

    logic [31:2]    w_instr;
    logic [6:0]     w_opcode;
    imm_fmt_e       w_fmt;
    logic           w_rs1_used;
    logic           w_rs2_used;
    logic           w_hazard;
    logic [31:0]    w_imm;
    execute_signals w_dec;
    execute_signals w_dec_imm;
    execute_signals r_out;

    assign w_instr       = bus.signals_in.instr;
    assign w_opcode      = {w_instr[6:2], 2'b11};
    assign bus.rs1_addr  = w_instr[19:15];
    assign bus.rs2_addr  = w_instr[24:20];

    imm_gen u_imm_gen (
        .instr  (w_instr),
        .format (w_fmt),
        .imm    (w_imm)
    );

    // Decode control fields, immediate format and which sources are read.
    // The filler (ADDI x0,x0,0) falls out as a bubble because rd==0 kills reg_we.
    always_comb begin
        w_dec           = EX_BUBBLE;
        w_dec.alu_op    = ALU_ADD;
        w_dec.src_a_sel = SRC_A_RS1;
        w_dec.src_b_sel = SRC_B_IMM;
        w_dec.rd        = w_instr[11:7];
        w_dec.rs1       = w_instr[19:15];
        w_dec.rs2       = w_instr[24:20];
        w_dec.funct3    = w_instr[14:12];
        w_dec.curr_pc   = bus.signals_in.curr_pc;
        w_dec.inc_pc    = bus.signals_in.inc_pc;
        w_fmt           = IMM_NONE;
        w_rs1_used      = 1'b0;
        w_rs2_used      = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.reg_we    = 1'b1;
                w_dec.src_a_sel = SRC_A_ZERO;
                w_fmt           = IMM_U;
            end
            OPC_AUIPC: begin
                w_dec.reg_we    = 1'b1;
                w_dec.src_a_sel = SRC_A_PC;
                w_fmt           = IMM_U;
            end
            OPC_JAL: begin
                w_dec.reg_we    = 1'b1;
                w_dec.jump      = 1'b1;
                w_dec.src_a_sel = SRC_A_PC;
                w_fmt           = IMM_J;
            end
            OPC_JALR: begin
                w_dec.reg_we = 1'b1;
                w_dec.jump   = 1'b1;
                w_dec.jalr   = 1'b1;
                w_fmt        = IMM_I;
                w_rs1_used   = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.branch    = 1'b1;
                w_dec.alu_op    = ALU_SUB;
                w_dec.src_b_sel = SRC_B_RS2;
                w_fmt           = IMM_B;
                w_rs1_used      = 1'b1;
                w_rs2_used      = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.reg_we = 1'b1;
                w_dec.mem_re = 1'b1;
                w_fmt        = IMM_I;
                w_rs1_used   = 1'b1;
            end
            OPC_STORE: begin
                w_dec.mem_we = 1'b1;
                w_fmt        = IMM_S;
                w_rs1_used   = 1'b1;
                w_rs2_used   = 1'b1;
            end
            OPC_OP_IMM: begin
                w_dec.reg_we = 1'b1;
                w_dec.alu_op = alu_from_funct3(w_instr[14:12],
                                               w_instr[30] && (w_instr[14:12] == 3'b101));
                w_fmt        = IMM_I;
                w_rs1_used   = 1'b1;
            end
            OPC_OP: begin
                w_dec.reg_we    = 1'b1;
                w_dec.alu_op    = alu_from_funct3(w_instr[14:12], w_instr[30]);
                w_dec.src_b_sel = SRC_B_RS2;
                w_rs1_used      = 1'b1;
                w_rs2_used      = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        if (w_dec.rd == 5'd0) begin
            w_dec.reg_we = 1'b0;
        end
    end

    // Merge the immediate in a separate process so the format select and
    // the imm_gen result never form a combinational loop through w_dec
    always_comb begin
        w_dec_imm     = w_dec;
        w_dec_imm.imm = w_imm;
    end

    assign w_hazard = (LOAD_USE_INTERLOCK != 0) && r_out.mem_re && (r_out.rd != 5'd0) &&
                      ((w_rs1_used && (r_out.rd == w_instr[19:15])) ||
                       (w_rs2_used && (r_out.rd == w_instr[24:20])));

    // A flush squashes the stalled instruction, so the interlock no longer matters
    assign bus.stall_out = bus.stall_in | (w_hazard & ~bus.flush);

    // ID/EX register: flush beats stall, stall beats hazard bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= EX_BUBBLE;
        end else if (bus.flush) begin
            r_out <= EX_BUBBLE;
        end else if (bus.stall_in) begin
            r_out <= r_out;
        end else if (w_hazard) begin
            r_out <= EX_BUBBLE;
        end else begin
            r_out <= w_dec_imm;
        end
    end

    assign bus.signals_out = r_out;

endmodule

// File: tb/tb_idu.sv
// Scoreboard bench for the decode stage: a behavioural RV32I model predicts
// each ID/EX payload, a monitor compares it one cycle later.
module tb_idu;
    import pipeline::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    idu_if bus ();

    idu #(.LOAD_USE_INTERLOCK(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    execute_signals exp_q[$];
    execute_signals m_ex;
    logic [31:0] pc;
    bit last_dut_stall;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        return v[bits-1] ? v - (32'd1 << bits) : v;
    endfunction

    // Reference decode written from the ISA rules
    function automatic execute_signals m_decode(input logic [31:0] ins, input logic [31:0] at_pc);
        execute_signals e;
        logic [2:0] f3;
        alu_op_e tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3 = ins[14:12];
        e = '0;
        e.rd = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.funct3 = f3;
        e.curr_pc = at_pc;
        e.inc_pc = at_pc + 32'd4;
        e.alu_op = ALU_ADD;
        e.src_a_sel = SRC_A_RS1;
        e.src_b_sel = SRC_B_IMM;
        case (ins[6:0])
            OPC_LUI:    begin e.reg_we = 1; e.src_a_sel = SRC_A_ZERO; e.imm = ins & 32'hFFFFF000; end
            OPC_AUIPC:  begin e.reg_we = 1; e.src_a_sel = SRC_A_PC; e.imm = ins & 32'hFFFFF000; end
            OPC_JAL: begin
                e.reg_we = 1; e.jump = 1; e.src_a_sel = SRC_A_PC;
                e.imm = sx(((ins >> 31) << 20) | (((ins >> 12) & 255) << 12) |
                           (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
            end
            OPC_JALR:   begin e.reg_we = 1; e.jump = 1; e.jalr = 1; e.imm = sx(ins >> 20, 12); end
            OPC_BRANCH: begin
                e.branch = 1; e.alu_op = ALU_SUB; e.src_b_sel = SRC_B_RS2;
                e.imm = sx(((ins >> 31) << 12) | (((ins >> 7) & 1) << 11) |
                           (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
            end
            OPC_LOAD:   begin e.reg_we = 1; e.mem_re = 1; e.imm = sx(ins >> 20, 12); end
            OPC_STORE:  begin e.mem_we = 1; e.imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 31), 12); end
            OPC_OP_IMM: begin
                e.reg_we = 1; e.imm = sx(ins >> 20, 12); e.alu_op = tbl[f3];
                if (f3 == 3'd5 && ins[30]) e.alu_op = ALU_SRA;
            end
            OPC_OP: begin
                e.reg_we = 1; e.src_b_sel = SRC_B_RS2; e.alu_op = tbl[f3];
                if (f3 == 3'd0 && ins[30]) e.alu_op = ALU_SUB;
                if (f3 == 3'd5 && ins[30]) e.alu_op = ALU_SRA;
            end
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: e.illegal = 1;
        endcase
        if (e.rd == 0) e.reg_we = 0;
        return e;
    endfunction

    function automatic bit m_reads(input logic [31:0] ins, input logic [4:0] r);
        case (ins[6:0])
            OPC_OP, OPC_BRANCH, OPC_STORE: return (r == ins[19:15]) || (r == ins[24:20]);
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: return r == ins[19:15];
            default: return 1'b0;
        endcase
    endfunction

    // Payloads with no enable only carry meaning in illegal and the pcs
    function automatic execute_signals norm(input execute_signals e);
        execute_signals n;
        n = e;
        if (!(e.reg_we | e.mem_re | e.mem_we | e.branch | e.jump)) begin
            n = '0;
            n.illegal = e.illegal;
            n.curr_pc = e.curr_pc;
            n.inc_pc = e.inc_pc;
        end
        return n;
    endfunction

    // Drive one cycle, check combinational outputs, push the predicted payload
    task automatic step(input logic [31:0] ins, input bit stl, input bit fl, output bit stalled);
        execute_signals dec, nxt;
        bit hz, exp_stall;
        bus.signals_in.instr = ins[31:2];
        bus.signals_in.curr_pc = pc;
        bus.signals_in.inc_pc = pc + 32'd4;
        bus.stall_in = stl;
        bus.flush = fl;
        #4;
        dec = m_decode(ins, pc);
        hz = m_ex.mem_re && (m_ex.rd != 0) && m_reads(ins, m_ex.rd);
        exp_stall = stl | (hz & !fl);
        last_dut_stall = bus.stall_out;
        chk("stall_out", 128'(bus.stall_out), 128'(exp_stall));
        chk("rs_addr", 128'({bus.rs1_addr, bus.rs2_addr}), 128'({ins[19:15], ins[24:20]}));
        if (fl) nxt = '0;
        else if (stl) nxt = m_ex;
        else if (hz) nxt = '0;
        else nxt = dec;
        exp_q.push_back(nxt);
        m_ex = nxt;
        stalled = exp_stall;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush = 1'b0;
        m_ex = '0;
        exp_q.delete();
        #1;
        chk("reset_state", bus.signals_out, 128'(0));
        chk("reset_stall", 128'(bus.stall_out), 128'(0));
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("stall_after_reset", 128'(bus.stall_out), 128'(0));
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] opcs [12];
        logic [6:0] bad [3];
        int k;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                 OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM, OPC_LOAD};
        bad = '{7'h7F, 7'h0B, 7'h5B};
        r = $urandom;
        r[11:7] = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 13);
        if (k < 12) r[6:0] = opcs[k];
        else if (k == 12) r = 32'h0000_0013;
        else r[6:0] = bad[$urandom_range(0, 2)];
        return r;
    endfunction

    // Monitor: one expected payload per clock edge that followed a step
    initial begin
        execute_signals e_exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e_exp = exp_q.pop_front();
                chk("signals_out", norm(bus.signals_out), norm(e_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        bit s, stl, fl;
        logic [31:0] cur;
        bus.signals_in = '0;
        bus.stall_in = 1'b0;
        bus.flush = 1'b0;
        m_ex = '0;
        pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", bus.signals_out, 128'(0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // ADDI x5,x1,-1
        step(32'hFFF08293, 0, 0, s);
        chk("addi_fields",
            128'({bus.signals_out.rd, bus.signals_out.rs1, bus.signals_out.imm, bus.signals_out.reg_we,
                  logic'(bus.signals_out.src_b_sel), bus.signals_out.curr_pc, bus.signals_out.inc_pc}),
            128'({5'd5, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h100, 32'h104}));
        pc += 4;

        // LW x6,0(x2) then ADD x7,x6,x3: one stall, one bubble
        step(32'h00012303, 0, 0, s);
        pc += 4;
        step(32'h003303B3, 0, 0, s);
        chk("lu_stall", 128'(last_dut_stall), 128'(1));
        chk("lu_bubble", 128'({bus.signals_out.reg_we, bus.signals_out.mem_re, bus.signals_out.curr_pc}), 128'(0));
        step(32'h003303B3, 0, 0, s);
        chk("lu_release", 128'(last_dut_stall), 128'(0));
        chk("lu_issue", 128'({bus.signals_out.rd, bus.signals_out.rs1, bus.signals_out.curr_pc}),
            128'({5'd7, 5'd6, pc}));
        pc += 4;

        // LW x0 then ADD reading x0: no interlock
        step(32'h00012003, 0, 0, s);
        pc += 4;
        step(32'h003003B3, 0, 0, s);
        chk("x0_no_stall", 128'(last_dut_stall), 128'(0));
        pc += 4;

        // BEQ with flush and stall_in together
        step(32'h00208463, 1, 1, s);
        chk("flush_stall", 128'(last_dut_stall), 128'(1));
        chk("flush_bubble", bus.signals_out, 128'(0));
        pc = 32'h200;

        // Filler then an unknown opcode
        step(32'h00000013, 0, 0, s);
        chk("filler_bubble",
            128'({bus.signals_out.reg_we, bus.signals_out.mem_re, bus.signals_out.mem_we, bus.signals_out.branch,
                  bus.signals_out.jump, bus.signals_out.illegal, bus.signals_out.curr_pc}),
            128'({6'b000000, pc}));
        pc += 4;
        step(32'h0000007F, 0, 0, s);
        chk("illegal_op",
            128'({bus.signals_out.reg_we, bus.signals_out.mem_re, bus.signals_out.mem_we, bus.signals_out.branch,
                  bus.signals_out.jump, bus.signals_out.illegal}),
            128'(6'b000001));
        pc += 4;

        // Reset during a load-use stall
        step(32'h00012303, 0, 0, s);
        pc += 4;
        step(32'h003303B3, 0, 0, s);
        chk("pre_reset_stall", 128'(last_dut_stall), 128'(1));
        do_reset();
        step(32'h003303B3, 0, 0, s);
        pc += 4;

        // Randomised stream with an ifu that holds on stall and redirects on flush
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            stl = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 9) == 0);
            step(cur, stl, fl, s);
            if (fl) begin
                pc = 32'($urandom_range(0, 1023)) << 2;
                cur = rand_instr();
            end else if (!s) begin
                pc += 4;
                cur = rand_instr();
            end
        end

        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
